arctic_grid_tx: RTL and testbench

//  Read-out transmitter for the Arctic Circle node array. On a start pulse it

---
 rtl/arctic_grid_tx.sv | 130 +++++++++++++
 tb/tb_arctic_grid_tx.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/arctic_grid_tx.sv
// Snapshots a grid of node states on start and streams it out as a framed byte sequence over valid/ready.
// Frame: 0xA5, then per row COLS bytes of (0x30 | state) followed by 0x0A; all outputs registered.
module arctic_grid_tx #(
    parameter int N    = 3,
    parameter int COLS = 4,
    parameter int ROWS = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [ROWS*COLS*(N+1)-1:0] grid,
    output logic [7:0]                 tx_data,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic                       busy,
    output logic                       done,
    output logic [7:0]                 frame_cnt
);

    localparam int W  = N + 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [RW-1:0] R_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] C_LAST = CW'(COLS - 1);

    typedef enum logic [1:0] {IDLE, HDR, CELL, EOL} state_t;

    state_t          state, state_nxt;
    logic [RW-1:0]   r, r_nxt;
    logic [CW-1:0]   c, c_nxt;
    logic [W-1:0]    snap [ROWS][COLS];
    logic            cap;
    logic            done_nxt;
    logic            xfer;
    logic [7:0]      data_nxt;

    assign xfer = tx_valid && tx_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            r         <= '0;
            c         <= '0;
            tx_data   <= 8'h00;
            tx_valid  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            frame_cnt <= 8'h00;
            for (int i = 0; i < ROWS; i++) begin
                for (int j = 0; j < COLS; j++) begin
                    snap[i][j] <= '0;
                end
            end
        end else begin
            state    <= state_nxt;
            r        <= r_nxt;
            c        <= c_nxt;
            tx_data  <= data_nxt;
            tx_valid <= (state_nxt != IDLE);
            busy     <= (state_nxt != IDLE);
            done     <= done_nxt;
            if (done_nxt) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
            if (cap) begin
                for (int i = 0; i < ROWS; i++) begin
                    for (int j = 0; j < COLS; j++) begin
                        snap[i][j] <= grid[(i*COLS + j)*W +: W];
                    end
                end
            end
        end
    end

    // Next-state logic; the output byte is derived from the next state so
    // tx_data is registered and already valid in the first cycle of each state.
    always_comb begin
        state_nxt = state;
        r_nxt     = r;
        c_nxt     = c;
        cap       = 1'b0;
        done_nxt  = 1'b0;
        data_nxt  = 8'h00;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = HDR;
                    cap       = 1'b1;
                end
            end
            HDR: begin
                if (xfer) begin
                    state_nxt = CELL;
                    r_nxt     = '0;
                    c_nxt     = '0;
                end
            end
            CELL: begin
                if (xfer) begin
                    if (c == C_LAST) begin
                        state_nxt = EOL;
                    end else begin
                        c_nxt = c + CW'(1);
                    end
                end
            end
            EOL: begin
                if (xfer) begin
                    if (r == R_LAST) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = CELL;
                        r_nxt     = r + RW'(1);
                        c_nxt     = '0;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        case (state_nxt)
            HDR:     data_nxt = 8'hA5;
            CELL:    data_nxt = 8'h30 | 8'(snap[r_nxt][c_nxt]);
            EOL:     data_nxt = 8'h0A;
            default: data_nxt = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_arctic_grid_tx.sv
// Randomized bench for arctic_grid_tx: a frame-level reference model queues expected bytes,
// a negedge monitor compares every handshake and the status outputs.
module tb_arctic_grid_tx;

    localparam int N    = 3;
    localparam int COLS = 4;
    localparam int ROWS = 4;
    localparam int GW   = ROWS*COLS*(N+1);
    localparam int FLEN = 1 + ROWS*(COLS+1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [GW-1:0] grid = '0;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b0;
    logic          busy;
    logic          done;
    logic [7:0]    frame_cnt;

    arctic_grid_tx #(.N(N), .COLS(COLS), .ROWS(ROWS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .grid      (grid),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .done      (done),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    bit         chk_en = 1'b0;

    // Reference model state: what the sink should see, frame by frame.
    logic [7:0] exp_q [$];
    bit         m_busy = 1'b0;
    bit         m_done = 1'b0;
    int         m_left = 0;
    logic [7:0] m_cnt = 8'h00;

    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Inputs change at posedge+1, so here they still hold what the DUT samples.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_left = 0;
            m_cnt  = 8'h00;
            exp_q.delete();
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                if (tx_ready) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_busy = 1'b0;
                        m_done = 1'b1;
                        m_cnt  = m_cnt + 8'd1;
                    end
                end
            end else if (start) begin
                exp_q.push_back(8'hA5);
                for (int rr = 0; rr < ROWS; rr++) begin
                    for (int cc = 0; cc < COLS; cc++) begin
                        exp_q.push_back(8'h30 | 8'(grid[(rr*COLS + cc)*(N+1) +: N+1]));
                    end
                    exp_q.push_back(8'h0A);
                end
                m_busy = 1'b1;
                m_left = FLEN;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("tx_valid", 32'(tx_valid), 32'(m_busy));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("done", 32'(done), 32'(m_done));
            chk("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
            if (prev_stall) chk("stall_data", 32'(tx_data), 32'(prev_data));
            if (tx_valid === 1'b1 && tx_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte at %0t: got %0h expected none", $time, tx_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    chk("tx_data", 32'(tx_data), 32'(e));
                end
            end
            prev_stall = rst_n && (tx_valid === 1'b1) && !tx_ready;
            prev_data  = tx_data;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic wait_frame(input int budget, input bit rand_ready);
        int k = 0;
        while (!m_done && k < budget) begin
            if (rand_ready) tx_ready = 1'($urandom_range(0, 1));
            cyc(1);
            k++;
        end
        tx_ready = 1'b1;
        if (!m_done) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout at %0t: got no done after %0d cycles expected done", $time, budget);
        end
    endtask

    initial begin
        int nframes;
        int k;

        cyc(2);
        chk_en = 1'b1;
        cyc(1);
        rst_n = 1'b1;
        tx_ready = 1'b1;
        cyc(2);

        // all-zero grid, full-rate sink
        grid = '0;
        pulse_start();
        wait_frame(100, 1'b0);
        cyc(3);

        // two marked corner cells
        grid = '0;
        grid[3:0] = 4'b0100;
        grid[63:60] = 4'b1010;
        pulse_start();
        wait_frame(100, 1'b0);
        cyc(2);

        // same grid, random sink stalls
        pulse_start();
        wait_frame(2000, 1'b1);
        cyc(2);

        // grid change and start while busy are ignored
        grid = {$urandom, $urandom};
        pulse_start();
        cyc(5);
        grid = {$urandom, $urandom};
        pulse_start();
        cyc(3);
        start = 1'b1;
        cyc(2);
        start = 1'b0;
        wait_frame(100, 1'b0);
        cyc(3);

        // reset after the 7th transfer, then a clean frame
        grid = {$urandom, $urandom};
        pulse_start();
        cyc(7);
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        cyc(2);
        grid = {$urandom, $urandom};
        pulse_start();
        wait_frame(100, 1'b0);
        cyc(2);

        // 256 back-to-back frames with the grid churning underneath
        nframes = 0;
        k = 0;
        start = 1'b1;
        while (nframes < 256 && k < 256*(FLEN+1) + 100) begin
            grid = {$urandom, $urandom};
            cyc(1);
            if (m_done) nframes++;
            k++;
        end
        start = 1'b0;
        chk("b2b_frames", 32'(nframes), 32'd256);
        cyc(FLEN + 5);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
